// File: rtl/i2c_slave_responder.sv
// I2C target with a small register file: pointer-byte writes, auto-incrementing
// burst writes and reads, no clock stretching.
module i2c_slave_responder #(
    parameter logic [6:0] SLAVE_ADDRESS          = 7'h68,
    parameter int         DATA_WIDTH             = 8,
    parameter int         REGISTER_ADDRESS_WIDTH = 8,
    parameter int         REG_DEPTH              = 16
) (
    input  logic                              pclk,
    input  logic                              areset,
    input  logic                              scl_i,
    input  logic                              sda_i,
    output logic                              sda_oe,
    output logic                              busy,
    output logic                              wr_pulse,
    output logic [REGISTER_ADDRESS_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0]             wr_data
);

    localparam int         PW       = $clog2(REG_DEPTH);
    localparam logic [3:0] LAST_BIT = 4'(DATA_WIDTH - 1);
    localparam logic [3:0] ALL_BITS = 4'(DATA_WIDTH);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
    } state_t;

    state_t                state, state_n;
    logic [1:0]            scl_sync, sda_sync;
    logic                  scl_d, sda_d;
    logic                  scl_s, sda_s;
    logic                  scl_rise, scl_fall, start_det, stop_det;
    logic [3:0]            cnt, cnt_n;
    logic [DATA_WIDTH-1:0] rx, rx_n, rx_shift;
    logic [DATA_WIDTH-1:0] tx, tx_n;
    logic [DATA_WIDTH-1:0] rd_byte;
    logic [PW-1:0]         ptr, ptr_n;
    logic                  rw, rw_n;
    logic                  oe_n, busy_n, wr_en;
    logic [DATA_WIDTH-1:0] regs [REG_DEPTH];

    always_ff @(posedge pclk or posedge areset) begin
        if (areset) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], scl_i};
            sda_sync <= {sda_sync[0], sda_i};
            scl_d    <= scl_sync[1];
            sda_d    <= sda_sync[1];
        end
    end

    assign scl_s     = scl_sync[1];
    assign sda_s     = sda_sync[1];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign start_det = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;
    assign rx_shift  = {rx[DATA_WIDTH-2:0], sda_s};
    assign rd_byte   = regs[ptr];

    always_ff @(posedge pclk or posedge areset) begin
        if (areset) begin
            state  <= IDLE;
            cnt    <= '0;
            rx     <= '0;
            tx     <= '0;
            ptr    <= '0;
            rw     <= 1'b0;
            sda_oe <= 1'b0;
            busy   <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            rx     <= rx_n;
            tx     <= tx_n;
            ptr    <= ptr_n;
            rw     <= rw_n;
            sda_oe <= oe_n;
            busy   <= busy_n;
        end
    end

    // In the ACK states cnt is a phase flag: 0 = waiting for the fall that starts
    // the ACK bit, 1 = waiting for the fall that ends it.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        rx_n    = rx;
        tx_n    = tx;
        ptr_n   = ptr;
        rw_n    = rw;
        oe_n    = sda_oe;
        busy_n  = busy;
        wr_en   = 1'b0;
        if (start_det) begin
            state_n = ADDR;
            cnt_n   = '0;
            oe_n    = 1'b0;
        end else if (stop_det) begin
            state_n = IDLE;
            cnt_n   = '0;
            oe_n    = 1'b0;
            busy_n  = 1'b0;
        end else begin
            case (state)
                IDLE: oe_n = 1'b0;
                ADDR: begin
                    if (scl_rise) begin
                        rx_n  = rx_shift;
                        cnt_n = cnt + 4'd1;
                        if (cnt == LAST_BIT) begin
                            cnt_n = '0;
                            if (rx_shift[DATA_WIDTH-1:1] == SLAVE_ADDRESS) begin
                                state_n = ADDR_ACK;
                                busy_n  = 1'b1;
                                rw_n    = rx_shift[0];
                            end else begin
                                state_n = IDLE;
                                busy_n  = 1'b0;
                            end
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        if (cnt == 4'd0) begin
                            oe_n  = 1'b1;
                            cnt_n = 4'd1;
                        end else if (rw) begin
                            state_n = RDATA;
                            oe_n    = ~rd_byte[DATA_WIDTH-1];
                            tx_n    = {rd_byte[DATA_WIDTH-2:0], 1'b0};
                            cnt_n   = 4'd1;
                        end else begin
                            state_n = REG;
                            oe_n    = 1'b0;
                            cnt_n   = '0;
                        end
                    end
                end
                REG: begin
                    if (scl_rise) begin
                        rx_n  = rx_shift;
                        cnt_n = cnt + 4'd1;
                        if (cnt == LAST_BIT) begin
                            ptr_n   = rx_shift[PW-1:0];
                            cnt_n   = '0;
                            state_n = REG_ACK;
                        end
                    end
                end
                REG_ACK, WDATA_ACK: begin
                    if (scl_fall) begin
                        if (cnt == 4'd0) begin
                            oe_n  = 1'b1;
                            cnt_n = 4'd1;
                        end else begin
                            oe_n    = 1'b0;
                            cnt_n   = '0;
                            state_n = WDATA;
                        end
                    end
                end
                WDATA: begin
                    if (scl_rise) begin
                        rx_n  = rx_shift;
                        cnt_n = cnt + 4'd1;
                        if (cnt == LAST_BIT) begin
                            wr_en   = 1'b1;
                            ptr_n   = ptr + PW'(1);
                            cnt_n   = '0;
                            state_n = WDATA_ACK;
                        end
                    end
                end
                RDATA: begin
                    if (scl_fall) begin
                        if (cnt < ALL_BITS) begin
                            oe_n  = ~tx[DATA_WIDTH-1];
                            tx_n  = {tx[DATA_WIDTH-2:0], 1'b0};
                            cnt_n = cnt + 4'd1;
                        end else begin
                            oe_n    = 1'b0;
                            cnt_n   = '0;
                            state_n = RDATA_ACK;
                        end
                    end
                end
                RDATA_ACK: begin
                    if (scl_rise && cnt == 4'd0) begin
                        if (!sda_s) begin
                            ptr_n = ptr + PW'(1);
                            cnt_n = 4'd1;
                        end else begin
                            state_n = IDLE;
                        end
                    end else if (scl_fall && cnt == 4'd1) begin
                        state_n = RDATA;
                        oe_n    = ~rd_byte[DATA_WIDTH-1];
                        tx_n    = {rd_byte[DATA_WIDTH-2:0], 1'b0};
                        cnt_n   = 4'd1;
                    end
                end
                default: begin
                    state_n = IDLE;
                    oe_n    = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge pclk or posedge areset) begin
        if (areset) begin
            for (int unsigned i = 0; i < REG_DEPTH; i++) regs[i] <= '0;
            wr_pulse <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
        end else begin
            wr_pulse <= wr_en;
            if (wr_en) begin
                regs[ptr] <= rx_shift;
                wr_addr   <= REGISTER_ADDRESS_WIDTH'(ptr);
                wr_data   <= rx_shift;
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Bench: bit-level I2C master, register-file model, and a per-cycle monitor for
// illegal SDA drive and write strobes.
module tb_i2c_slave_responder;

    localparam int Q_NS = 100;
    localparam int H_NS = 100;

    logic       pclk = 1'b0;
    logic       areset;
    logic       scl_m, sda_m;
    logic       sda_line;
    logic       sda_oe, busy, wr_pulse;
    logic [7:0] wr_addr, wr_data;

    always #5 pclk = ~pclk;
    assign sda_line = sda_m & ~sda_oe;

    i2c_slave_responder #(
        .SLAVE_ADDRESS(7'h68),
        .DATA_WIDTH(8),
        .REGISTER_ADDRESS_WIDTH(8),
        .REG_DEPTH(16)
    ) dut (
        .pclk(pclk),
        .areset(areset),
        .scl_i(scl_m),
        .sda_i(sda_line),
        .sda_oe(sda_oe),
        .busy(busy),
        .wr_pulse(wr_pulse),
        .wr_addr(wr_addr),
        .wr_data(wr_data)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;

    int         checks = 0;
    int         errors = 0;
    logic       allow_drive = 1'b0;
    logic [7:0] mreg [16];
    int         mptr = 0;
    wr_t        expq [$];
    logic [7:0] wq [$];
    logic [7:0] got [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge pclk) begin
        if (!allow_drive) begin
            checks++;
            if (sda_oe !== 1'b0) begin
                errors++;
                $display("FAIL sda_oe_window at %0t: got %b, expected 0", $time, sda_oe);
            end
        end
        if (wr_pulse === 1'b1) begin
            checks++;
            if (expq.size() == 0) begin
                errors++;
                $display("FAIL wr_pulse_unexpected: got addr %0h data %0h, expected no write", wr_addr, wr_data);
            end else begin
                wr_t e;
                e = expq.pop_front();
                if (wr_addr !== e.a || wr_data !== e.d) begin
                    errors++;
                    $display("FAIL wr_strobe: got addr %0h data %0h, expected addr %0h data %0h",
                             wr_addr, wr_data, e.a, e.d);
                end
            end
        end
    end

    task automatic clk_bit(input logic bo, input logic allow_next, output logic bi);
        sda_m = bo;
        #(Q_NS);
        scl_m = 1'b1;
        #(H_NS);
        bi = sda_line;
        #(H_NS);
        if (allow_next) allow_drive = 1'b1;
        scl_m = 1'b0;
        #(Q_NS);
        if (!allow_next) allow_drive = 1'b0;
    endtask

    task automatic i2c_start;
        sda_m = 1'b1; #(Q_NS);
        scl_m = 1'b1; #(Q_NS);
        sda_m = 1'b0; #(Q_NS);
        scl_m = 1'b0; #(Q_NS);
    endtask

    task automatic i2c_stop;
        sda_m = 1'b0; #(Q_NS);
        scl_m = 1'b1; #(Q_NS);
        sda_m = 1'b1; #(Q_NS);
    endtask

    task automatic write_byte(input logic [7:0] b, input logic exp_ack, input logic allow_after,
                              output logic ack);
        logic x, r;
        for (int unsigned i = 0; i < 7; i++) clk_bit(b[7-i], 1'b0, x);
        clk_bit(b[0], exp_ack, x);
        clk_bit(1'b1, allow_after, r);
        ack = ~r;
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] b);
        logic x;
        for (int unsigned i = 0; i < 7; i++) begin
            clk_bit(1'b1, 1'b1, x);
            b[7-i] = x;
        end
        clk_bit(1'b1, 1'b0, x);
        b[0] = x;
        clk_bit(~mack, mack, x);
    endtask

    // Register write burst: bytes come from wq.
    task automatic tx_write(input logic [7:0] reg_a);
        logic ack;
        wr_t  e;
        i2c_start;
        write_byte(8'hD0, 1'b1, 1'b0, ack);
        check("addr_ack_w", ack, 1);
        check("busy_addressed", busy, 1);
        write_byte(reg_a, 1'b1, 1'b0, ack);
        check("reg_ack", ack, 1);
        mptr = reg_a % 16;
        foreach (wq[k]) begin
            e.a = 8'(mptr);
            e.d = wq[k];
            expq.push_back(e);
            mreg[mptr] = wq[k];
            mptr = (mptr + 1) % 16;
            write_byte(wq[k], 1'b1, 1'b0, ack);
            check("data_ack", ack, 1);
        end
        i2c_stop;
        check("busy_after_stop_w", busy, 0);
    endtask

    // Pointer write, repeated START, n-byte read; last byte NACKed.
    task automatic tx_read(input logic [7:0] reg_a, input int n);
        logic       ack;
        logic [7:0] b;
        got.delete();
        i2c_start;
        write_byte(8'hD0, 1'b1, 1'b0, ack);
        check("addr_ack_pw", ack, 1);
        write_byte(reg_a, 1'b1, 1'b0, ack);
        check("reg_ack_pw", ack, 1);
        mptr = reg_a % 16;
        i2c_start;
        write_byte(8'hD1, 1'b1, 1'b1, ack);
        check("addr_ack_r", ack, 1);
        for (int k = 0; k < n; k++) begin
            read_byte(k < n - 1, b);
            check("rdata", b, mreg[mptr]);
            got.push_back(b);
            if (k < n - 1) mptr = (mptr + 1) % 16;
        end
        i2c_stop;
        check("busy_after_stop_r", busy, 0);
    endtask

    initial begin
        logic ack, x;
        logic [7:0] pat;
        #20_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       ack, x;
        logic [7:0] pat;
        for (int unsigned i = 0; i < 16; i++) mreg[i] = 8'h00;
        areset = 1'b1;
        scl_m  = 1'b1;
        sda_m  = 1'b1;
        #100;
        check("rst_sda_oe", sda_oe, 0);
        check("rst_busy", busy, 0);
        check("rst_wr_pulse", wr_pulse, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        areset = 1'b0;
        #200;

        // Single-byte write, then a two-byte burst behind it.
        wq.delete(); wq.push_back(8'hA5);
        tx_write(8'h03);
        wq.delete(); wq.push_back(8'h3C); wq.push_back(8'hC3);
        tx_write(8'h04);

        tx_read(8'h03, 2);
        check("read_lit0", got[0], 8'hA5);
        check("read_lit1", got[1], 8'h3C);

        // Foreign address: never acknowledged, never driven.
        i2c_start;
        write_byte(8'hA0, 1'b0, 1'b0, ack);
        check("mismatch_nack", ack, 0);
        check("mismatch_busy", busy, 0);
        write_byte(8'h55, 1'b0, 1'b0, ack);
        check("mismatch_nack2", ack, 0);
        i2c_stop;

        // Pointer wrap on both write and read.
        wq.delete(); wq.push_back(8'h11); wq.push_back(8'h22);
        tx_write(8'h0F);
        tx_read(8'h0F, 2);
        check("wrap_lit15", got[0], 8'h11);
        check("wrap_lit0", got[1], 8'h22);

        // STOP after four data bits must not write.
        i2c_start;
        write_byte(8'hD0, 1'b1, 1'b0, ack);
        check("midstop_addr_ack", ack, 1);
        write_byte(8'h07, 1'b1, 1'b0, ack);
        check("midstop_reg_ack", ack, 1);
        pat = 8'hA0;
        for (int unsigned i = 0; i < 4; i++) clk_bit(pat[7-i], 1'b0, x);
        i2c_stop;
        check("midstop_busy", busy, 0);
        check("midstop_sda_oe", sda_oe, 0);
        tx_read(8'h07, 1);
        check("midstop_lit", got[0], 8'h00);

        // Reset asserted while the address ACK is being driven.
        i2c_start;
        pat = 8'hD0;
        for (int unsigned i = 0; i < 7; i++) clk_bit(pat[7-i], 1'b0, x);
        clk_bit(pat[0], 1'b1, x);
        sda_m = 1'b1;
        #(Q_NS);
        scl_m = 1'b1;
        #(H_NS);
        check("ack_before_reset", sda_oe, 1);
        areset = 1'b1;
        #1;
        check("reset_async_release", sda_oe, 0);
        allow_drive = 1'b0;
        #(H_NS - 1);
        scl_m = 1'b0;
        #(Q_NS);
        for (int unsigned i = 0; i < 16; i++) mreg[i] = 8'h00;
        mptr = 0;
        expq.delete();
        areset = 1'b0;
        check("post_reset_busy", busy, 0);
        check("post_reset_wr_addr", wr_addr, 0);
        check("post_reset_wr_data", wr_data, 0);
        // Clocking an address without START must be ignored.
        write_byte(8'hD0, 1'b0, 1'b0, ack);
        check("no_start_ignored", ack, 0);
        i2c_stop;
        tx_read(8'h03, 2);
        check("reset_clear_lit3", got[0], 8'h00);
        check("reset_clear_lit4", got[1], 8'h00);

        #500;
        check("writes_all_seen", expq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i2c_slave_responder.md
I2C_SLAVE_RESPONDER -- requirements
Module: i2c_slave_responder

Interface
REQ-001 SHALL have parameter SLAVE_ADDRESS, default 7'h68, the 7-bit address this target answers to.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, the bits per data byte; only 8 is supported.
REQ-003 SHALL have parameter REGISTER_ADDRESS_WIDTH, default 8, the width of the register pointer byte.
REQ-004 SHALL have parameter REG_DEPTH, default 16, the number of internal registers (power of 2).
REQ-005 SHALL have port pclk, input, 1, the single system clock; all logic is on its rising edge.
REQ-006 SHALL have port areset, input, 1, the asynchronous active-high reset.
REQ-007 SHALL have port scl_i, input, 1, the bus SCL level (asynchronous to pclk).
REQ-008 SHALL have port sda_i, input, 1, the bus SDA level (asynchronous to pclk).
REQ-009 SHALL have port sda_oe, output, 1, which pulls SDA low when 1 and releases it when 0 (open-drain).
REQ-010 SHALL have port busy, output, 1, high while addressed, from the address match until STOP or mismatch.
REQ-011 SHALL have port wr_pulse, output, 1, a one-pclk strobe per data byte written.
REQ-012 SHALL have port wr_addr, output, REGISTER_ADDRESS_WIDTH, the register index of the last write.
REQ-013 SHALL have port wr_data, output, DATA_WIDTH, the byte of the last write.

Function
REQ-014 SHALL pass scl_i and sda_i through 2-flop synchronizers, then 1 delay flop for edge detection; bus events lag 3 pclk.
REQ-015 SHALL detect START as synced SDA falling while synced SCL is high.
REQ-016 SHALL detect STOP as synced SDA rising while synced SCL is high.
REQ-017 SHALL sample bits on synced SCL rising edge, MSB first.
REQ-018 SHALL change sda_oe only on synced SCL falling edge.
REQ-019 SHALL implement FSM states IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.
REQ-020 SHALL on START go from any state to ADDR, clear the bit counter and release sda_oe; repeated START included.
REQ-021 SHALL on STOP go from any state to IDLE and release sda_oe; START/STOP take priority over a same-cycle bit edge.
REQ-022 SHALL in ADDR collect 7 address bits plus R/W; on a match go to ADDR_ACK, on a mismatch go to IDLE with no drive.
REQ-023 SHALL in ADDR_ACK drive sda_oe=1 from the SCL fall after bit 8 until the next SCL fall.
REQ-024 SHALL after ADDR_ACK go to REG if W; if R, go to RDATA from the current pointer.
REQ-025 SHALL in REG latch the pointer byte, keeping the low log2(REG_DEPTH) bits, then ACK (REG_ACK), then go to WDATA.
REQ-026 SHALL in WDATA, at bit 8, write the register, pulse wr_pulse for 1 pclk with wr_addr/wr_data, ACK, and increment the pointer.
REQ-027 SHALL in RDATA drive sda_oe = ~bit, MSB at the ADDR_ACK/prior-ACK fall and each later bit at each SCL fall.
REQ-028 SHALL release sda_oe at the 8th-bit fall, then sample the master ACK on SCL rise (RDATA_ACK).
REQ-029 SHALL on master ACK (SDA=0) increment the pointer and continue RDATA.
REQ-030 SHALL on master NACK (SDA=1) stay released and idle until STOP/START.
REQ-031 SHALL wrap the pointer modulo REG_DEPTH on increment.
REQ-032 SHALL perform no clock stretching; sda_oe is never asserted in IDLE.

Reset
REQ-033 SHALL while areset is high force state IDLE, sda_oe=0, busy=0, wr_pulse=0, wr_addr=0, wr_data=0, pointer=0, all registers 0, synchronizers to 1.
REQ-034 SHALL on areset mid-transfer immediately release SDA and ignore bus activity until the next START.

Verification
REQ-035 SHALL cover write: START, 0xD0, ACK, reg 0x03, ACK, 0xA5, ACK, STOP -> reg[3]=0xA5, one wr_pulse with wr_addr=3/wr_data=0xA5, three ACKs.
REQ-036 SHALL cover read: write-pointer 0x03, repeated START, 0xD1, read 2 bytes ACK then NACK -> SDA carries 0xA5, then reg[4].
REQ-037 SHALL cover mismatch: START, 0xA0 -> sda_oe stays 0 for the whole frame, busy=0.
REQ-038 SHALL cover wrap: pointer 0x0F, write 0x11, 0x22 -> reg[15]=0x11, reg[0]=0x22.
REQ-039 SHALL cover mid-byte STOP: STOP after 4 data bits -> no write, IDLE, sda_oe=0.
REQ-040 SHALL cover reset mid-ACK: areset while sda_oe=1 -> sda_oe=0 within the same cycle, all registers 0.
